// File: rtl/bus_arbiter_541_pkg.sv
// Shared definitions for the 74x541 bus arbiter.
//   state_t : FSM state encoding (ST_IDLE, ST_OWN, ST_DEAD)
//   clog2   : index width helper; never returns less than 1 so that a
//             two-requester arbiter still gets a 1-bit owner port.
package bus_arbiter_541_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_arbiter_541_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   last   : index of the previous owner; the search starts at last+1
//   onehot : one-hot winner (all zero when no request)
//   index  : winner index (equals last when no request)
//   any    : high when at least one request is present
// The previous owner is searched last, so it only wins when nobody
// else is asking.
module bus_arbiter_541_rr_pick
  import bus_arbiter_541_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          any
);

  always_comb begin
    int k;
    k      = 0;
    onehot = '0;
    index  = last;
    any    = 1'b0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last) + i) % N;
      if (!any && req[k]) begin
        any       = 1'b1;
        onehot[k] = 1'b1;
        index     = IW'(k);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_541.sv
// Shared-bus arbiter driving the active-low output enables of one
// 74x541 octal buffer per requester.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   req   : per-requester bus request, held while the bus is needed
//   grant : registered one-hot grant, zero when nobody owns the bus
//   noe   : registered active-low buffer enables, always ~grant
//   owner : index of the current or most recent owner
//   busy  : high while owning or in the turnaround gap
// Between two tenures all buffers float for DEAD cycles so that two
// 541s never fight on the bus. MAX_TENURE bounds a tenure only while
// another requester is waiting (0 disables the limit).
module bus_arbiter_541
  import bus_arbiter_541_pkg::*;
#(
  parameter int N          = 4,
  parameter int DEAD       = 1,
  parameter int MAX_TENURE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req,
  output logic [N-1:0]        grant,
  output logic [N-1:0]        noe,
  output logic [clog2(N)-1:0] owner,
  output logic                busy
);

  localparam int IW = clog2(N);
  localparam int TW = clog2(MAX_TENURE + 2);
  localparam int DW = clog2(DEAD + 1);

  localparam logic          TEN_EN   = (MAX_TENURE != 0);
  localparam logic [TW-1:0] TEN_LAST = (MAX_TENURE == 0) ? '0 : TW'(MAX_TENURE - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD - 1);

  state_t        state;
  logic [TW-1:0] tenure;
  logic [DW-1:0] dead_cnt;

  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_index;
  logic          pick_any;
  logic          others;
  logic          expire;

  bus_arbiter_541_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .last   (owner),
    .onehot (pick_onehot),
    .index  (pick_index),
    .any    (pick_any)
  );

  // Someone other than the current owner is asking for the bus.
  assign others = |(req & ~grant);
  assign expire = TEN_EN && (tenure == TEN_LAST) && others;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      grant    <= '0;
      noe      <= '1;
      owner    <= IW'(N - 1);
      busy     <= 1'b0;
      tenure   <= '0;
      dead_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state  <= ST_OWN;
            grant  <= pick_onehot;
            noe    <= ~pick_onehot;
            owner  <= pick_index;
            busy   <= 1'b1;
            tenure <= '0;
          end
        end

        ST_OWN: begin
          if (!req[owner] || expire) begin
            state    <= ST_DEAD;
            grant    <= '0;
            noe      <= '1;
            dead_cnt <= '0;
          end else if (TEN_EN && tenure != TEN_LAST) begin
            // Saturates at the limit: a requester arriving after the
            // owner has already used its full tenure takes over after
            // the very next edge.
            tenure <= tenure + 1'b1;
          end
        end

        ST_DEAD: begin
          if (dead_cnt == DEAD_LAST) begin
            // req is re-sampled here, so requests that vanished during
            // the gap are not granted.
            if (pick_any) begin
              state  <= ST_OWN;
              grant  <= pick_onehot;
              noe    <= ~pick_onehot;
              owner  <= pick_index;
              tenure <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            dead_cnt <= dead_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          grant <= '0;
          noe   <= '1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter_541.md
Name: bus_arbiter_541

Overview:
- Arbitrates one shared bus between N requesters. Each requester drives the bus through its own 74x541 octal buffer.
- Generates the registered, active-low output enables (noe) for those buffers.
- Guarantees at most one buffer drives the bus at any time, with forced all-float turnaround cycles between owners.
- Sits between the bus-master control logic and the buffer bank.

Parameters:
- N, 4, number of requesters and buffers (2..8).
- DEAD, 1, turnaround cycles with all buffers tri-stated between two owners (>=1).
- MAX_TENURE, 16, maximum consecutive owned cycles while another requester waits (0 = unlimited).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request per requester; held high for as long as the bus is needed.
- grant  output  N  one-hot registered grant (all zero when no owner).
- noe  output  N  active-low buffer enables; always equal to ~grant; wired to noe1 of each 541.
- owner  output  clog2(N)  index of the current or last owner.
- busy  output  1  high while in OWN or DEAD.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, grant=0, noe=all ones, owner=N-1 (so requester 0 has first priority), busy=0, tenure and dead counters 0.
- Reset mid-ownership takes effect at the next edge: noe goes all ones with no dead-cycle sequencing.
- States: IDLE, OWN, DEAD (registered FSM).
- IDLE:
  - If req != 0, pick the winner round-robin: first set bit searching owner+1, owner+2, ... modulo N.
  - Register grant, noe and owner for the winner; go to OWN.
  - Latency from req sampled to noe low: 1 cycle.
- OWN:
  - Tenure counter clears on entry and increments each OWN cycle.
  - Leave to DEAD at the next edge if req[owner]=0.
  - Also leave to DEAD if MAX_TENURE!=0, tenure==MAX_TENURE-1 and any other req bit is set. The owner then holds the bus exactly MAX_TENURE cycles.
  - If no other requester is waiting, tenure expiry is ignored and ownership continues.
  - On leaving, grant=0 and noe=all ones in the same edge.
- DEAD:
  - Stays DEAD exactly DEAD cycles with noe all ones.
  - On the last DEAD cycle, arbitrate exactly as in IDLE, with priority starting from owner+1.
  - If req=0, go to IDLE instead.
  - req is re-sampled at this point; requests that dropped during DEAD are not granted.
- Invariants (checked every cycle by the bench):
  - popcount(~noe) <= 1.
  - noe == ~grant.
  - A change of owner always has >= DEAD intervening cycles of noe all ones.
  - noe never goes low for a requester whose req was low at the deciding edge.
- The previous owner re-requesting has lowest priority while others wait. It may be re-granted after DEAD if it is the only requester.
- X or Z on req is not defined behaviour. The bench drives only 0/1.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_OWN, ST_DEAD.
  - owner width function clog2.
- One sub-module: rr_pick, combinational round-robin picker.
  - Inputs: req[N], last[clog2 N].
  - Outputs: onehot[N], index, any.
- Counters and FSM stay in bus_arbiter_541.

Test Plan (N=4, DEAD=1, MAX_TENURE=4):
- Reset held 2 cycles with req=1111 -> noe=1111, grant=0000, busy=0, owner=3. First grant after release goes to requester 0.
- From IDLE, req=0100 -> next edge grant=0100, noe=1011, owner=2. Held while req[2]=1. Drop req[2] -> next edge noe=1111, busy=1 for 1 cycle, then IDLE with busy=0.
- From IDLE with owner=3, req=0110 -> grant=0010. Drop req[1] -> exactly 1 cycle noe=1111, then grant=0100.
- req=0011 held continuously -> sequence repeats with no overlap:
  - grant=0001 for 4 cycles, noe=1111 for 1 cycle;
  - grant=0010 for 4 cycles, noe=1111 for 1 cycle;
  - grant=0001 again.
- req=1000 held 20 cycles alone -> grant=1000 continuously for 20 cycles; tenure expiry is ignored.
- Reset pulsed during OWN with grant=0100 -> next edge noe=1111, owner=3, state IDLE.
- All scenarios: the invariant checker passes. On a violation it prints FAIL with time and values; on success it prints OK at the end.
